// File: rtl/cep_elam_pkg.sv
// Shared types for the CEP ELAM capture block: capture state encoding,
// default view widths and the trace entry layout.
package cep_elam_pkg;

    // Capture state; encodings are visible on the capState port.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } cap_state_e;

    // Default view widths of the ELAM mux outputs.
    localparam int CEP_DATA_W = 128;
    localparam int CEP_CTL_W  = 32;

    // Trace entry at default widths, also the rdData layout {ctl1, ctl0, data}.
    typedef struct packed {
        logic [CEP_CTL_W-1:0]  ctl1;
        logic [CEP_CTL_W-1:0]  ctl0;
        logic [CEP_DATA_W-1:0] data;
    } cep_entry_t;

    // True while the capture engine owns the buffer (reads are refused).
    function automatic logic is_capturing(input cap_state_e st);
        return (st == ST_ARMED) || (st == ST_POST);
    endfunction

endpackage

// File: rtl/cep_elam_trace_ram.sv
// Trace buffer storage: one write port, one synchronously read port,
// no reset. Kept as a separate module so a vendor RAM macro can replace it.
module cep_elam_trace_ram #(
    parameter int WIDTH = 192,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Write port.
    // NOTE: storage arrays carry no reset so they map onto RAM macros; readers must never expose unwritten entries.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Synchronous read port; output holds between reads.
    always_ff @(posedge i_clk) begin
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/cep_elam_capture.sv
// CEP ELAM capture: samples data view 0 and control views 0/1 into a
// circular trace buffer while armed, stops a programmable number of samples
// after a masked-match trigger, and serves oldest-first reads once frozen.
module cep_elam_capture
    import cep_elam_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int CTL_WIDTH  = 32,
    parameter int DEPTH      = 16,
    localparam int PTR_W     = $clog2(DEPTH)
) (
    input  logic                              sysClk,
    input  logic                              sysResetN,
    input  logic [DATA_WIDTH-1:0]             elamData0,
    input  logic [CTL_WIDTH-1:0]              elamControl0,
    input  logic [CTL_WIDTH-1:0]              elamControl1,
    input  logic                              cfgArm,
    input  logic                              cfgDisarm,
    input  logic                              cfgTrigSrc,
    input  logic [CTL_WIDTH-1:0]              cfgMatchVal,
    input  logic [CTL_WIDTH-1:0]              cfgMatchMask,
    input  logic [PTR_W-1:0]                  cfgPostCount,
    output logic [1:0]                        capState,
    output logic                              capTriggered,
    output logic                              capWrapped,
    output logic [PTR_W:0]                    capCount,
    output logic [PTR_W-1:0]                  capTrigOffset,
    input  logic                              rdReq,
    input  logic [PTR_W-1:0]                  rdAddr,
    output logic                              rdValid,
    output logic                              rdErr,
    output logic [DATA_WIDTH+2*CTL_WIDTH-1:0] rdData
);

    localparam int              ENTRY_W   = DATA_WIDTH + 2 * CTL_WIDTH;
    localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

    // Entry layout at this instance's widths; matches cep_entry_t at defaults.
    typedef struct packed {
        logic [CTL_WIDTH-1:0]  ctl1;
        logic [CTL_WIDTH-1:0]  ctl0;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    // Input stage and capture control state.
    entry_t           r_s1;
    cap_state_e       r_state;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_trig_ptr;
    logic [PTR_W-1:0] r_post_rem;
    logic [PTR_W:0]   r_count;
    logic             r_triggered;
    logic             r_wrapped;
    logic             r_rd_valid;
    logic             r_rd_err;

    logic [CTL_WIDTH-1:0] w_s1_ctl;
    logic                 w_match;
    logic                 w_wr_en;
    logic [PTR_W-1:0]     w_oldest;
    logic [PTR_W-1:0]     w_rd_phys;
    logic                 w_rd_reject;
    logic                 w_rd_en;
    logic [ENTRY_W-1:0]   w_ram_q;

    // Register the ELAM views once; compare and write both act on this stage.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge sysClk) begin
        r_s1.ctl1 <= elamControl1;
        r_s1.ctl0 <= elamControl0;
        r_s1.data <= elamData0;
    end

    // Trigger compare, write enable and read address/acceptance decode.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_s1_ctl    = r_s1.ctl0;
        w_match     = 1'b0;
        w_wr_en     = 1'b0;
        w_oldest    = '0;
        w_rd_phys   = '0;
        w_rd_reject = 1'b0;
        w_rd_en     = 1'b0;

        if (cfgTrigSrc) begin
            w_s1_ctl = r_s1.ctl1;
        end
        w_match = (((w_s1_ctl ^ cfgMatchVal) & cfgMatchMask) == '0);

        // Arm and disarm cycles never write.
        w_wr_en = is_capturing(r_state) && !cfgArm && !cfgDisarm;

        if (r_wrapped) begin
            w_oldest = r_wr_ptr;
        end
        // PTR_W-bit addition wraps modulo DEPTH for free.
        w_rd_phys   = w_oldest + rdAddr;
        w_rd_reject = is_capturing(r_state) || ({1'b0, rdAddr} >= r_count);
        w_rd_en     = rdReq && !w_rd_reject;
    end

    // Capture FSM: arm/disarm handling, pointer bookkeeping, trigger and post-count.
    always_ff @(posedge sysClk) begin
        if (!sysResetN) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_trig_ptr  <= '0;
            r_post_rem  <= '0;
            r_count     <= '0;
            r_triggered <= 1'b0;
            r_wrapped   <= 1'b0;
        end else if (cfgDisarm) begin
            // Disarm beats a simultaneous arm; the buffer is left untouched.
            if (is_capturing(r_state)) begin
                r_state <= ST_IDLE;
            end
        end else if (cfgArm) begin
            r_state     <= ST_ARMED;
            r_wr_ptr    <= '0;
            r_trig_ptr  <= '0;
            r_post_rem  <= '0;
            r_count     <= '0;
            r_triggered <= 1'b0;
            r_wrapped   <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
                if (r_wr_ptr == LAST_PTR) begin
                    r_wrapped <= 1'b1;
                end
                if (r_count != FULL_CNT) begin
                    r_count <= r_count + CNT_ONE;
                end
            end

            case (r_state)
                ST_ARMED: begin
                    if (w_match) begin
                        r_triggered <= 1'b1;
                        r_trig_ptr  <= r_wr_ptr;
                        r_post_rem  <= cfgPostCount;
                        r_state     <= (cfgPostCount == '0) ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: begin
                    // Post count is below DEPTH, so the trigger entry survives.
                    r_post_rem <= r_post_rem - PTR_ONE;
                    if (r_post_rem == PTR_ONE) begin
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Read response: one valid pulse per request, error flag registered alongside.
    always_ff @(posedge sysClk) begin
        if (!sysResetN) begin
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
        end else begin
            r_rd_valid <= rdReq;
            r_rd_err   <= rdReq && w_rd_reject;
        end
    end

    cep_elam_trace_ram #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_trace_ram (
        .i_clk     (sysClk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (r_s1),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_phys),
        .o_rd_data (w_ram_q)
    );

    assign capState      = r_state;
    assign capTriggered  = r_triggered;
    assign capWrapped    = r_wrapped;
    assign capCount      = r_count;
    assign capTrigOffset = r_trig_ptr - w_oldest;
    assign rdValid       = r_rd_valid;
    assign rdErr         = r_rd_err;
    // RAM output is only exposed for accepted reads; otherwise zero.
    assign rdData        = (r_rd_valid && !r_rd_err) ? w_ram_q : '0;

endmodule

// File: tb/tb_cep_elam_capture.sv
// Self-checking bench for cep_elam_capture: table-driven readback plus
// directed sequences for trigger, disarm, arm/disarm collision and reset.
module tb_cep_elam_capture;

    localparam int DW = 128;
    localparam int CW = 32;
    localparam int DEPTH = 16;
    localparam int PW = 4;
    localparam int EW = DW + 2 * CW;

    logic          sysClk = 1'b0;
    logic          sysResetN;
    logic [DW-1:0] elamData0;
    logic [CW-1:0] elamControl0;
    logic [CW-1:0] elamControl1;
    logic          cfgArm;
    logic          cfgDisarm;
    logic          cfgTrigSrc;
    logic [CW-1:0] cfgMatchVal;
    logic [CW-1:0] cfgMatchMask;
    logic [PW-1:0] cfgPostCount;
    logic [1:0]    capState;
    logic          capTriggered;
    logic          capWrapped;
    logic [PW:0]   capCount;
    logic [PW-1:0] capTrigOffset;
    logic          rdReq;
    logic [PW-1:0] rdAddr;
    logic          rdValid;
    logic          rdErr;
    logic [EW-1:0] rdData;

    int n_pass = 0;
    int n_total = 0;
    logic [31:0] idx;

    typedef struct {
        logic [PW-1:0] addr;
        logic          exp_err;
        logic [31:0]   exp_v;
    } rd_vec_t;

    rd_vec_t vecs[$];

    cep_elam_capture #(
        .DATA_WIDTH (DW),
        .CTL_WIDTH  (CW),
        .DEPTH      (DEPTH)
    ) dut (
        .sysClk        (sysClk),
        .sysResetN     (sysResetN),
        .elamData0     (elamData0),
        .elamControl0  (elamControl0),
        .elamControl1  (elamControl1),
        .cfgArm        (cfgArm),
        .cfgDisarm     (cfgDisarm),
        .cfgTrigSrc    (cfgTrigSrc),
        .cfgMatchVal   (cfgMatchVal),
        .cfgMatchMask  (cfgMatchMask),
        .cfgPostCount  (cfgPostCount),
        .capState      (capState),
        .capTriggered  (capTriggered),
        .capWrapped    (capWrapped),
        .capCount      (capCount),
        .capTrigOffset (capTrigOffset),
        .rdReq         (rdReq),
        .rdAddr        (rdAddr),
        .rdValid       (rdValid),
        .rdErr         (rdErr),
        .rdData        (rdData)
    );

    always #5 sysClk = ~sysClk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Full entry {ctl1, ctl0, data} the bench drives for sample value v.
    function automatic logic [EW-1:0] entry_of(input logic [31:0] v);
        return {~v, v, v, ~v, v ^ 32'h5A5A_0000, v + 32'd3};
    endfunction

    task automatic drive();
        logic [EW-1:0] e;
        e = entry_of(idx);
        elamControl1 = e[EW-1 -: CW];
        elamControl0 = e[DW +: CW];
        elamData0    = e[DW-1:0];
    endtask

    task automatic tick();
        @(posedge sysClk);
        #1;
    endtask

    task automatic step();
        tick();
        idx = idx + 32'd1;
        drive();
    endtask

    // The sample present on the arm edge is the first one written.
    task automatic arm(input logic [31:0] start);
        idx = start;
        drive();
        cfgArm = 1'b1;
        tick();
        cfgArm = 1'b0;
        idx = idx + 32'd1;
        drive();
    endtask

    task automatic rd_check(input string name, input logic [PW-1:0] addr,
                            input logic exp_err, input logic [EW-1:0] exp_data);
        rdReq  = 1'b1;
        rdAddr = addr;
        tick();
        rdReq = 1'b0;
        check({name, ".valid"}, EW'(rdValid), EW'(1'b1));
        check({name, ".err"}, EW'(rdErr), EW'(exp_err));
        check({name, ".data"}, rdData, exp_data);
    endtask

    task automatic run_vectors(input string name);
        foreach (vecs[i]) begin
            rd_check($sformatf("%s[%0d]", name, i), vecs[i].addr, vecs[i].exp_err,
                     vecs[i].exp_err ? '0 : entry_of(vecs[i].exp_v));
        end
    endtask

    initial begin
        sysResetN    = 1'b0;
        idx          = '0;
        drive();
        cfgArm       = 1'b0;
        cfgDisarm    = 1'b0;
        cfgTrigSrc   = 1'b0;
        cfgMatchVal  = '0;
        cfgMatchMask = '0;
        cfgPostCount = '0;
        rdReq        = 1'b0;
        rdAddr       = '0;

        // Reset state.
        tick();
        tick();
        check("rst.state", EW'(capState), EW'(2'd0));
        check("rst.valid", EW'(rdValid), EW'(1'b0));
        check("rst.count", EW'(capCount), EW'(0));
        check("rst.trig", EW'(capTriggered), EW'(0));
        sysResetN = 1'b1;
        tick();

        // Wrapping capture: trigger on ctl0 == 0xA5, three post samples.
        cfgMatchMask = 32'hFFFF_FFFF;
        cfgMatchVal  = 32'h0000_00A5;
        cfgTrigSrc   = 1'b0;
        cfgPostCount = 4'd3;
        arm(32'h0);
        check("t1.armed", EW'(capState), EW'(2'd1));
        for (int c = 0; c < 400 && capState != 2'd3; c++) begin
            step();
        end
        check("t1.done", EW'(capState), EW'(2'd3));
        check("t1.trig", EW'(capTriggered), EW'(1'b1));
        check("t1.wrap", EW'(capWrapped), EW'(1'b1));
        check("t1.count", EW'(capCount), EW'(16));
        check("t1.offset", EW'(capTrigOffset), EW'(12));
        // Last 16 written samples are 0x99..0xA8, oldest first.
        vecs.delete();
        for (int i = 0; i < 16; i++) begin
            vecs.push_back('{addr: PW'(i), exp_err: 1'b0, exp_v: 32'h99 + 32'(i)});
        end
        run_vectors("t1.rd");
        tick();
        check("t1.valid_drop", EW'(rdValid), EW'(1'b0));
        check("t1.frozen", EW'(capCount), EW'(16));

        // Zero mask, zero post: first armed sample triggers.
        cfgMatchMask = '0;
        cfgPostCount = '0;
        arm(32'h200);
        step();
        check("t2.done", EW'(capState), EW'(2'd3));
        check("t2.count", EW'(capCount), EW'(1));
        check("t2.offset", EW'(capTrigOffset), EW'(0));
        check("t2.wrap", EW'(capWrapped), EW'(0));
        check("t2.trig", EW'(capTriggered), EW'(1));
        rd_check("t2.rd0", 4'd0, 1'b0, entry_of(32'h200));
        rd_check("t2.rd1", 4'd1, 1'b1, '0);

        // Disarm after five samples; entries remain readable.
        cfgMatchMask = 32'hFFFF_FFFF;
        cfgMatchVal  = 32'hDEAD_BEEF;
        cfgPostCount = 4'd2;
        arm(32'h10);
        repeat (5) step();
        cfgDisarm = 1'b1;
        step();
        cfgDisarm = 1'b0;
        check("t3.idle", EW'(capState), EW'(2'd0));
        check("t3.count", EW'(capCount), EW'(5));
        check("t3.trig", EW'(capTriggered), EW'(0));
        vecs.delete();
        for (int i = 0; i < 5; i++) begin
            vecs.push_back('{addr: PW'(i), exp_err: 1'b0, exp_v: 32'h10 + 32'(i)});
        end
        vecs.push_back('{addr: 4'd5, exp_err: 1'b1, exp_v: 32'h0});
        run_vectors("t3.rd");

        // Read while armed is refused; arm+disarm together leaves IDLE untouched.
        arm(32'h50);
        step();
        rd_check("t4.rd_armed", 4'd0, 1'b1, '0);
        cfgDisarm = 1'b1;
        tick();
        cfgDisarm = 1'b0;
        check("t4.idle", EW'(capState), EW'(2'd0));
        check("t4.count", EW'(capCount), EW'(2));
        cfgArm    = 1'b1;
        cfgDisarm = 1'b1;
        tick();
        cfgArm    = 1'b0;
        cfgDisarm = 1'b0;
        check("t4.both_idle", EW'(capState), EW'(2'd0));
        check("t4.both_count", EW'(capCount), EW'(2));

        // Reset during POST, then re-arm on control view 1.
        cfgMatchVal  = 32'h30;
        cfgPostCount = 4'd5;
        arm(32'h2C);
        for (int c = 0; c < 50 && capState != 2'd2; c++) begin
            step();
        end
        check("t5.post", EW'(capState), EW'(2'd2));
        sysResetN = 1'b0;
        rdReq     = 1'b1;
        rdAddr    = '0;
        tick();
        rdReq = 1'b0;
        check("t5.rst_state", EW'(capState), EW'(0));
        check("t5.rst_trig", EW'(capTriggered), EW'(0));
        check("t5.rst_wrap", EW'(capWrapped), EW'(0));
        check("t5.rst_count", EW'(capCount), EW'(0));
        check("t5.rst_offset", EW'(capTrigOffset), EW'(0));
        check("t5.rst_valid", EW'(rdValid), EW'(0));
        check("t5.rst_err", EW'(rdErr), EW'(0));
        check("t5.rst_data", rdData, '0);
        sysResetN = 1'b1;
        cfgTrigSrc   = 1'b1;
        cfgMatchVal  = ~32'h42;
        cfgPostCount = 4'd2;
        arm(32'h40);
        for (int c = 0; c < 50 && capState != 2'd3; c++) begin
            step();
        end
        check("t5.done", EW'(capState), EW'(2'd3));
        check("t5.count", EW'(capCount), EW'(5));
        check("t5.offset", EW'(capTrigOffset), EW'(2));
        check("t5.trig", EW'(capTriggered), EW'(1));
        rd_check("t5.rd2", 4'd2, 1'b0, entry_of(32'h42));
        rd_check("t5.rd4", 4'd4, 1'b0, entry_of(32'h44));
        rd_check("t5.rd5", 4'd5, 1'b1, '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
